// File: rtl/ip_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the ROM and registers IF/ID; BOOT/RUN/HALT control FSM.
// Optional FETCH_BOUNDS_CHECK_EN adds fetch_fault and bubbles/halts on fetches beyond the 64-word ROM.
module ip_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        load_bubble, load_fetch;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_plus4;
  logic        unused_rpc_lsb;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic fault_q, fault_d;
`endif

  assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
  assign pc_plus4       = pc_q + 32'd4;
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_bubble = 1'b0;
    load_fetch  = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d     = fault_q;
`endif
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        // A redirect defers any halt request by one cycle.
        if (redirect_valid) begin
          pc_d        = redirect_tgt;
          load_bubble = 1'b1;
        end else if (halt_req && !resume) begin
          load_bubble = 1'b1;
          state_d     = S_HALT;
        end else if (!stall) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          if (|pc_q[31:8]) begin
            load_bubble = 1'b1;
            fault_d     = 1'b1;
            state_d     = S_HALT;
          end else
`endif
          begin
            load_fetch = 1'b1;
            pc_d       = pc_plus4;
          end
        end
      end
      S_HALT: begin
        load_bubble = 1'b1;
        if (redirect_valid) pc_d = redirect_tgt;
`ifdef FETCH_BOUNDS_CHECK_EN
        if (resume && !fault_q) state_d = S_RUN;
`else
        if (resume) state_d = S_RUN;
`endif
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (load_bubble) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (load_fetch) begin
      inst_d  = rom_inst;
      ipc_d   = pc_q;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      ipc_q   <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
  assign fetch_fault = fault_q;
`endif

  assign pc_addr     = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc    = ipc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == S_HALT);

endmodule
